window_9x9_sequencer: RTL and testbench
=======================================

// Module: window_9x9_sequencer
// PURPOSE
//   Sequences the 9x9 window-buffer datapath for one streaming frame. Tracks the column
//   and row position of each 9-tall pixel column leaving the line buffers, and gates the
//   window shift registers. Flags when a full 9x9 window is present, and tags it with its
//   top-left coordinate. Pulses frame completion.
//   Sits between the 9-line buffer stage and the 9x9 window register array / kernel stage.
// PARAMETERS
//   COLS   11  pixels per image row (>= K)
//   ROWS   11  rows per image (>= K)
//   K      9   window size; fixed, taken from the shared package, not overridden
// PORTS
//   clk           in   1            rising-edge clock
//   rst           in   1            synchronous, active-high reset
//   col_valid_i   in   1            a valid 9-tall column is on S1_i..S9_i this cycle
//   shift_en_o    out  1            window array shifts in column (= col_valid_i, combinational)
//   win_valid_o   out  1            window array holds a complete 9x9 window (registered)
//   win_col_o     out  CW           window left column, 0..COLS-K; CW=$clog2(COLS)
//   win_row_o     out  RW           window top row, 0..ROWS-K; RW=$clog2(ROWS)
//   busy_o        out  1            frame in progress: at least one column accepted, not done
//   done_o        out  1            one-cycle pulse together with the frame's last win_valid_o
// BEHAVIOUR
//   Reset: all outputs 0, col_cnt=0, row_cnt=0, state=IDLE. Reset wins over col_valid_i.
//     Reset mid-frame discards the frame; no done_o is issued.
//   Counters:
//     - col_cnt runs 0..COLS-1.
//     - row_cnt runs 0..ROWS-K (line-buffer output rows, not image rows).
//     - Both advance only on a cycle with col_valid_i=1 (accepted column).
//     - On an accepted column with col_cnt==COLS-1: col_cnt->0, row_cnt+1.
//     - If row_cnt==ROWS-K at that point as well, row_cnt->0 (frame wrap).
//   FSM (registered state):
//     - IDLE: col_valid_i -> FILL.
//     - FILL: col_cnt < K-1, window not yet full. An accepted column with col_cnt==K-2 -> SLIDE.
//     - SLIDE: an accepted column with col_cnt==COLS-1 -> FILL for the next row. On the last
//       row it goes -> IDLE instead.
//     - The K-1 columns at the start of each row refill the window.
//     - Windows never straddle rows.
//   Outputs (1-cycle latency, aligned with the window regs loaded on the same edge):
//     - win_valid_o <= col_valid_i && col_cnt >= K-1
//     - win_col_o   <= col_cnt-(K-1)
//     - win_row_o   <= row_cnt
//     - win_col_o / win_row_o hold their value while win_valid_o=0.
//     - done_o <= col_valid_i && col_cnt==COLS-1 && row_cnt==ROWS-K
//     - busy_o is 1 from the first accepted column up to and including the done_o cycle,
//       else 0.
//   Stalls: col_valid_i=0 mid-row freezes counters and state; win_valid_o drops to 0 next cycle.
//   Back-to-back frames: col_valid_i may be high in the cycle after the last column.
//     That column is col 0 / row 0 of the next frame; no idle gap is required.
//   Windows per frame = (COLS-K+1)*(ROWS-K+1).
//     Emitted row-major, one per accepted column with col_cnt >= K-1.
//   Degenerate case COLS==K: exactly one window per row, emitted on col_cnt==K-1.
// STRUCTURE
//   Shared package window_pkg:
//     - K_WIN=9
//     - state enum {IDLE, FILL, SLIDE}
//     - width function clog2 used for CW/RW
//     - the same package serves the 3x3/5x5 variants
//   One sub-module, wb_pos_counter:
//     - a wrapping counter with params MAX and W
//     - inputs en; outputs cnt and wrap (en && cnt==MAX)
//     - instanced twice: columns, with rows enabled by the column wrap
//   FSM and output registers live in the top module.
// TESTING (COLS=ROWS=11 unless stated)
//   1 Reset, then 33 consecutive col_valid_i:
//     - 9 win_valid_o pulses, (col,row) = (0,0),(1,0),(2,0),(0,1)..(2,2)
//     - done_o coincident with (2,2); busy_o low the cycle after
//   2 Stall: col_valid_i low for 5 cycles after column 9 of row 0:
//     - counters hold, win_valid_o low for those 5 cycles
//     - resume gives win (1,0) then (2,0)
//   3 Back-to-back: frame 2 starts the cycle after done_o:
//     - first frame-2 window (0,0) appears 9 columns later
//     - exactly 9 windows and 1 done_o per frame
//   4 Reset asserted together with col_valid_i at mid-frame column 15:
//     - all outputs 0 next cycle; no done_o
//     - a following full frame behaves as in test 1
//   5 COLS=9, ROWS=10: 18 columns give windows (0,0),(0,1); done_o with (0,1)
//   6 Random col_valid_i gaps over 3 frames:
//     - scoreboard the window count (9 per frame) and coordinates against a reference
//       position model

Source files
------------

// File: rtl/window_pkg.sv
// Shared definitions for the KxK window sequencers (3x3, 5x5, 9x9 variants).
// Holds the window size, the sequencer state encoding and a width helper.
package window_pkg;

    localparam int K_WIN = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SLIDE = 2'd2
    } win_state_e;

    // Bits needed to hold 0..value-1; never less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_pos_counter.sv
// Wrapping position counter: counts 0..MAX on each enabled cycle.
// wrap_o flags the enabled cycle on which the counter returns to 0.
module wb_pos_counter #(
    parameter int MAX = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == MAX_V);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/window_9x9_sequencer.sv
// Sequences the 9x9 window array: tracks column/row of each line-buffer column,
// flags complete windows with their top-left coordinate and pulses frame done.
module window_9x9_sequencer
    import window_pkg::*;
#(
    parameter int  COLS = 11,
    parameter int  ROWS = 11,
    localparam int CW   = clog2(COLS),
    localparam int RW   = clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          col_valid_i,
    output logic          shift_en_o,
    output logic          win_valid_o,
    output logic [CW-1:0] win_col_o,
    output logic [RW-1:0] win_row_o,
    output logic          busy_o,
    output logic          done_o,
    output win_state_e    state_o
);

    localparam logic [CW-1:0] FULL_COL = CW'(K_WIN - 1);
    localparam logic [CW-1:0] FILL_END = CW'(K_WIN - 2);

    // col_valid_i is a valid with no ready: every cycle it is high, the column is
    // accepted, counters advance and the window array shifts.
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          col_wrap;
    logic          row_wrap;

    win_state_e    state_q, state_d;
    logic          win_valid_q, win_valid_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic          done_q, done_d;

    wb_pos_counter #(.MAX(COLS - 1), .W(CW)) u_col_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (col_valid_i),
        .cnt_o  (col_cnt),
        .wrap_o (col_wrap)
    );

    // Rows here are line-buffer output rows, so the last one is ROWS-K.
    wb_pos_counter #(.MAX(ROWS - K_WIN), .W(RW)) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (col_wrap),
        .cnt_o  (row_cnt),
        .wrap_o (row_wrap)
    );

    always_comb begin
        state_d     = state_q;
        win_valid_d = col_valid_i && (col_cnt >= FULL_COL);
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        done_d      = row_wrap;
        if (win_valid_d) begin
            win_col_d = col_cnt - FULL_COL;
            win_row_d = row_cnt;
        end
        case (state_q)
            IDLE: begin
                if (col_valid_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (col_valid_i && (col_cnt == FILL_END)) begin
                    state_d = SLIDE;
                end
            end
            SLIDE: begin
                if (col_wrap) begin
                    state_d = row_wrap ? IDLE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            done_q      <= done_d;
        end
    end

    // The FSM is back in IDLE during the done cycle, so done_q extends busy through it.
    assign busy_o      = (state_q != IDLE) || done_q;
    assign shift_en_o  = col_valid_i;
    assign win_valid_o = win_valid_q;
    assign win_col_o   = win_col_q;
    assign win_row_o   = win_row_q;
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_window_9x9_sequencer.sv
// Bench for window_9x9_sequencer: an 11x11 instance and a 9x10 instance, each
// with an expected-window queue popped by its own output monitor.
module tb_window_9x9_sequencer;
    import window_pkg::*;

    localparam int COLS_A = 11;
    localparam int ROWS_A = 11;
    localparam int COLS_B = 9;
    localparam int ROWS_B = 10;
    localparam int CW_A   = clog2(COLS_A);
    localparam int RW_A   = clog2(ROWS_A);
    localparam int CW_B   = clog2(COLS_B);
    localparam int RW_B   = clog2(ROWS_B);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, col_valid_a, shift_en_a, win_valid_a, busy_a, done_a;
    logic [CW_A-1:0] win_col_a;
    logic [RW_A-1:0] win_row_a;
    win_state_e      state_a;

    logic            rst_b, col_valid_b, shift_en_b, win_valid_b, busy_b, done_b;
    logic [CW_B-1:0] win_col_b;
    logic [RW_B-1:0] win_row_b;
    win_state_e      state_b;

    window_9x9_sequencer #(.COLS(COLS_A), .ROWS(ROWS_A)) dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .col_valid_i (col_valid_a),
        .shift_en_o  (shift_en_a),
        .win_valid_o (win_valid_a),
        .win_col_o   (win_col_a),
        .win_row_o   (win_row_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .state_o     (state_a)
    );

    window_9x9_sequencer #(.COLS(COLS_B), .ROWS(ROWS_B)) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .col_valid_i (col_valid_b),
        .shift_en_o  (shift_en_b),
        .win_valid_o (win_valid_b),
        .win_col_o   (win_col_b),
        .win_row_o   (win_row_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .state_o     (state_b)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {done, row[3:0], col[3:0]}
    logic [8:0] exp_qa[$];
    logic [8:0] exp_qb[$];
    int checks = 0;
    int passes = 0;
    int win_cnt_a = 0, done_cnt_a = 0, win_cnt_b = 0, done_cnt_b = 0;
    int m_col[2];
    int m_row[2];
    bit use_model = 1'b0;

    function automatic logic [8:0] pack(input bit d, input int r, input int c);
        return {d, 4'(r), 4'(c)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference position model; pushes an expected window when use_model is set.
    task automatic model_accept(input int sel);
        int cols, rows;
        logic [8:0] e;
        cols = (sel == 0) ? COLS_A : COLS_B;
        rows = (sel == 0) ? ROWS_A : ROWS_B;
        if (m_col[sel] >= K_WIN - 1) begin
            e = pack((m_col[sel] == cols - 1) && (m_row[sel] == rows - K_WIN),
                     m_row[sel], m_col[sel] - (K_WIN - 1));
            if (use_model) begin
                if (sel == 0) exp_qa.push_back(e);
                else exp_qb.push_back(e);
            end
        end
        if (m_col[sel] == cols - 1) begin
            m_col[sel] = 0;
            m_row[sel] = (m_row[sel] == rows - K_WIN) ? 0 : m_row[sel] + 1;
        end else begin
            m_col[sel]++;
        end
    endtask

    // Hand-computed 11x11 frame: 3x3 windows row-major, done on the last.
    task automatic push_table_a();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp_qa.push_back(pack((r == 2) && (c == 2), r, c));
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input int sel, input logic v, input logic r);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            col_valid_a = v;
            rst_a       = r;
        end else begin
            col_valid_b = v;
            rst_b       = r;
        end
        if (r) begin
            m_col[sel] = 0;
            m_row[sel] = 0;
        end else if (v) begin
            model_accept(sel);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        check("shift_en_a", shift_en_a, col_valid_a);
        if (win_valid_a === 1'b1) begin
            win_cnt_a++;
            if (done_a === 1'b1) done_cnt_a++;
            if (exp_qa.size() == 0) begin
                checks++;
                $display("FAIL win_a_unexpected: got col %0d row %0d done %0b, expected none",
                         win_col_a, win_row_a, done_a);
            end else begin
                check("win_a", {done_a, win_row_a, win_col_a}, exp_qa.pop_front());
            end
        end else if (done_a === 1'b1) begin
            done_cnt_a++;
            checks++;
            $display("FAIL done_a_alone: got done 1 with win_valid 0, expected done with a window");
        end
    end

    always @(negedge clk) begin
        check("shift_en_b", shift_en_b, col_valid_b);
        if (win_valid_b === 1'b1) begin
            win_cnt_b++;
            if (done_b === 1'b1) done_cnt_b++;
            if (exp_qb.size() == 0) begin
                checks++;
                $display("FAIL win_b_unexpected: got col %0d row %0d done %0b, expected none",
                         win_col_b, win_row_b, done_b);
            end else begin
                check("win_b", {done_b, win_row_b, win_col_b}, exp_qb.pop_front());
            end
        end else if (done_b === 1'b1) begin
            done_cnt_b++;
            checks++;
            $display("FAIL done_b_alone: got done 1 with win_valid 0, expected done with a window");
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0, d0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        col_valid_a = 1'b0;
        col_valid_b = 1'b0;
        m_col[0] = 0; m_row[0] = 0;
        m_col[1] = 0; m_row[1] = 0;

        cyc(0, 1'b0, 1'b1);
        cyc(0, 1'b0, 1'b1);
        cyc(0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_win_valid", win_valid_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_win_col", win_col_a, 0);
        check("rst_win_row", win_row_a, 0);
        check("rst_state", state_a, IDLE);

        // Test 1: one full frame of 33 back-to-back columns
        use_model = 1'b0;
        w0 = win_cnt_a; d0 = done_cnt_a;
        push_table_a();
        for (int i = 0; i < 33; i++) begin
            cyc(0, 1'b1, 1'b0);
            if (i == 2) begin
                @(negedge clk);
                check("t1_busy_mid", busy_a, 1'b1);
            end
        end
        cyc(0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", done_a, 1'b1);
        check("t1_busy_on_done", busy_a, 1'b1);
        cyc(0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_busy_after", busy_a, 1'b0);
        check("t1_done_after", done_a, 1'b0);
        check("t1_hold_col", win_col_a, 2);
        check("t1_hold_row", win_row_a, 2);
        check("t1_state_idle", state_a, IDLE);
        cyc(0, 1'b0, 1'b0);
        check("t1_win_count", win_cnt_a - w0, 9);
        check("t1_done_count", done_cnt_a - d0, 1);

        // Test 2: stall for 5 cycles after column 9 of row 0
        use_model = 1'b1;
        w0 = win_cnt_a; d0 = done_cnt_a;
        for (int i = 0; i < 9; i++) cyc(0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b0, 1'b0);
            if (i > 0) begin
                @(negedge clk);
                check("t2_stall_valid", win_valid_a, 1'b0);
                check("t2_stall_hold_col", win_col_a, 0);
            end
        end
        cyc(0, 1'b1, 1'b0);
        @(negedge clk);
        check("t2_stall_valid_last", win_valid_a, 1'b0);
        for (int i = 0; i < 23; i++) cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        check("t2_win_count", win_cnt_a - w0, 9);
        check("t2_done_count", done_cnt_a - d0, 1);

        // Test 3: two frames with no gap between them
        w0 = win_cnt_a; d0 = done_cnt_a;
        for (int i = 0; i < 66; i++) begin
            cyc(0, 1'b1, 1'b0);
            if (i == 41 || i == 42) begin
                @(negedge clk);
                check("t3_frame2_first_win", win_valid_a, (i == 42));
            end
        end
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        check("t3_win_count", win_cnt_a - w0, 18);
        check("t3_done_count", done_cnt_a - d0, 2);

        // Test 4: reset together with a valid column mid-frame
        d0 = done_cnt_a;
        for (int i = 0; i < 15; i++) cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b1);
        cyc(0, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_win_valid", win_valid_a, 1'b0);
        check("t4_done", done_a, 1'b0);
        check("t4_busy", busy_a, 1'b0);
        check("t4_win_col", win_col_a, 0);
        check("t4_win_row", win_row_a, 0);
        cyc(0, 1'b0, 1'b0);
        check("t4_no_done", done_cnt_a - d0, 0);
        use_model = 1'b0;
        w0 = win_cnt_a; d0 = done_cnt_a;
        push_table_a();
        for (int i = 0; i < 33; i++) cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        check("t4_win_count", win_cnt_a - w0, 9);
        check("t4_done_count", done_cnt_a - d0, 1);

        // Test 6: random gaps over three frames, checked against the position model
        use_model = 1'b1;
        w0 = win_cnt_a; d0 = done_cnt_a;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 33; c++) begin
                repeat ($urandom_range(0, 3)) cyc(0, 1'b0, 1'b0);
                cyc(0, 1'b1, 1'b0);
            end
        end
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        check("t6_win_count", win_cnt_a - w0, 27);
        check("t6_done_count", done_cnt_a - d0, 3);

        // Test 5: 9x10 instance, one window per row, two rows
        use_model = 1'b0;
        cyc(1, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b0);
        exp_qb.push_back(pack(1'b0, 0, 0));
        exp_qb.push_back(pack(1'b1, 1, 0));
        for (int i = 0; i < 18; i++) cyc(1, 1'b1, 1'b0);
        cyc(1, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_done_pulse", done_b, 1'b1);
        check("t5_busy_on_done", busy_b, 1'b1);
        cyc(1, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_busy_after", busy_b, 1'b0);
        cyc(1, 1'b0, 1'b0);
        check("t5_win_count", win_cnt_b, 2);
        check("t5_done_count", done_cnt_b, 1);

        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        check("drain_qa", exp_qa.size(), 0);
        check("drain_qb", exp_qb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
